// File: rtl/seven_seg_mux_scanner_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: FSM encoding
// and the active-high {g,f,e,d,c,b,a} glyph constants.
package seven_seg_mux_scanner_pkg;

  typedef enum logic {
    GUARD  = 1'b0,
    ACTIVE = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/seven_seg_mux_scanner_hex.sv
// Combinational hex nibble to active-high segment pattern; polarity is left
// to whoever drives the pins.
module hex_to_seven_seg
  import seven_seg_mux_scanner_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_OFF;
    case (nibble)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      4'hF: pattern = SEG_F;
      default: pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_mux_scanner.sv
// N-digit multiplexed seven-segment scanner: prescaled dwell, dark guard gap
// between digits, per-digit blank/dp, and a polarity-aware registered output stage.
module seven_seg_mux_scanner
  import seven_seg_mux_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 100000,
  parameter int GUARD_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         dp,
  input  logic [NUM_DIGITS-1:0]         blank,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [6:0]                    seg,
  output logic                          dp_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int GC_W  = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic POL = ACTIVE_LOW;

  scan_state_e      state, state_nxt;
  logic [PRE_W-1:0] pre_cnt;
  logic [GC_W-1:0]  guard_cnt;
  logic             lit_win, tick, guard_done, lit;
  logic [3:0]       nibble;
  logic [6:0]       pattern;
  logic [NUM_DIGITS-1:0] anode_hi;
  logic [6:0]       seg_hi;
  logic             dp_hi;

  // With no guard time the GUARD state is just a one-cycle hop, so it must
  // still light the digit to keep the dwell at exactly TICK_DIV cycles.
  assign lit_win    = (state == ACTIVE) || (GUARD_CYCLES == 0);
  assign tick       = lit_win && (pre_cnt == PRE_W'(TICK_DIV - 1));
  assign guard_done = (GUARD_CYCLES == 0) || (guard_cnt == GC_W'(GUARD_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= GUARD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) state_nxt = GUARD;
    else begin
      case (state)
        GUARD:   if (guard_done) state_nxt = ACTIVE;
        ACTIVE:  if (tick)       state_nxt = GUARD;
        default: state_nxt = GUARD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt   <= '0;
      guard_cnt <= '0;
      digit_idx <= '0;
    end else if (!enable) begin
      pre_cnt   <= '0;
      guard_cnt <= '0;
    end else begin
      if (lit_win) pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (state == GUARD && GUARD_CYCLES != 0)
        guard_cnt <= guard_done ? '0 : guard_cnt + 1'b1;
      if (tick)
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
    end
  end

  assign nibble = digits[4*digit_idx +: 4];

  hex_to_seven_seg u_dec (
    .nibble  (nibble),
    .pattern (pattern)
  );

  always_comb begin
    lit      = enable && lit_win && !blank[digit_idx];
    anode_hi = '0;
    seg_hi   = SEG_OFF;
    dp_hi    = 1'b0;
    if (lit) begin
      anode_hi[digit_idx] = 1'b1;
      seg_hi              = pattern;
      dp_hi               = dp[digit_idx];
    end
  end

  // Anode and cathodes share one register stage so they can never tear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode <= {NUM_DIGITS{POL}};
      seg   <= {7{POL}};
      dp_n  <= POL;
    end else begin
      anode <= anode_hi ^ {NUM_DIGITS{POL}};
      seg   <= seg_hi ^ {7{POL}};
      dp_n  <= dp_hi ^ POL;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux_scanner.sv
// Directed bench: an active-low and an active-high scanner share stimulus and
// are each checked against hand-derived anode/seg/dp/index values.
module tb_seven_seg_mux_scanner;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [15:0] digits;
  logic [3:0]  dp, blank;
  logic [3:0]  anode_l, anode_h;
  logic [6:0]  seg_l, seg_h;
  logic        dp_n_l, dp_n_h;
  logic [1:0]  idx_l, idx_h;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seven_seg_mux_scanner #(.NUM_DIGITS(4), .TICK_DIV(4), .GUARD_CYCLES(2), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .digits(digits), .dp(dp), .blank(blank),
    .anode(anode_l), .seg(seg_l), .dp_n(dp_n_l), .digit_idx(idx_l)
  );

  seven_seg_mux_scanner #(.NUM_DIGITS(4), .TICK_DIV(4), .GUARD_CYCLES(2), .ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .reset(reset), .enable(enable), .digits(digits), .dp(dp), .blank(blank),
    .anode(anode_h), .seg(seg_h), .dp_n(dp_n_h), .digit_idx(idx_h)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // a/s/p are the active-high expectations; the low-polarity copy is their inverse.
  task automatic chk_out(input string tag, input logic [3:0] a, input logic [6:0] s, input logic p);
    logic [3:0] na;
    logic [6:0] ns;
    logic       np;
    na = ~a;
    ns = ~s;
    np = ~p;
    chk({tag, ".anode_l"}, anode_l, na);
    chk({tag, ".seg_l"},   seg_l,   ns);
    chk({tag, ".dp_n_l"},  dp_n_l,  np);
    chk({tag, ".anode_h"}, anode_h, a);
    chk({tag, ".seg_h"},   seg_h,   s);
    chk({tag, ".dp_n_h"},  dp_n_h,  p);
  endtask

  task automatic chk_idx(input string tag, input int d);
    logic [1:0] e;
    e = 2'(d);
    chk({tag, ".idx_l"}, idx_l, e);
    chk({tag, ".idx_h"}, idx_h, e);
  endtask

  // One slot: two dark guard cycles, then four lit cycles.
  task automatic slot(input int d, input logic [6:0] s, input logic blk, input logic p);
    logic [3:0] a;
    a = blk ? 4'b0000 : 4'(1 << d);
    repeat (2) begin
      step();
      chk_out($sformatf("guard%0d", d), 4'b0000, 7'h00, 1'b0);
      chk_idx($sformatf("guard%0d", d), d);
    end
    repeat (4) begin
      step();
      chk_out($sformatf("lit%0d", d), a, blk ? 7'h00 : s, blk ? 1'b0 : p);
    end
  endtask

  task automatic frame(input logic [3:0] blk, input logic [3:0] pd);
    slot(0, SEG_TAB[digits[3:0]],   blk[0], pd[0]);
    slot(1, SEG_TAB[digits[7:4]],   blk[1], pd[1]);
    slot(2, SEG_TAB[digits[11:8]],  blk[2], pd[2]);
    slot(3, SEG_TAB[digits[15:12]], blk[3], pd[3]);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    digits = 16'h1234;
    dp     = 4'b0000;
    blank  = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 4'b0000, 7'h00, 1'b0);
    chk_idx("reset", 0);

    // Release and two full frames of 4,3,2,1 with guard gaps, then wrap.
    reset = 1'b0;
    frame(4'b0000, 4'b0000);
    frame(4'b0000, 4'b0000);

    // Blanked slot 2 keeps its timing; dp only on digit 0.
    blank = 4'b0100;
    dp    = 4'b0001;
    frame(4'b0100, 4'b0001);
    blank = 4'b0000;
    dp    = 4'b0000;

    // Drop enable two cycles into digit 2, then resume at digit 2.
    slot(0, SEG_TAB[4], 1'b0, 1'b0);
    slot(1, SEG_TAB[3], 1'b0, 1'b0);
    repeat (2) begin
      step();
      chk_out("pre_en_guard", 4'b0000, 7'h00, 1'b0);
    end
    repeat (2) begin
      step();
      chk_out("pre_en_lit", 4'b0100, SEG_TAB[2], 1'b0);
    end
    enable = 1'b0;
    step();
    chk_out("en_off", 4'b0000, 7'h00, 1'b0);
    chk_idx("en_off", 2);
    step();
    chk_out("en_off2", 4'b0000, 7'h00, 1'b0);
    chk_idx("en_off2", 2);
    enable = 1'b1;
    slot(2, SEG_TAB[2], 1'b0, 1'b0);
    slot(3, SEG_TAB[1], 1'b0, 1'b0);

    // Asynchronous reset in the middle of a lit slot.
    repeat (2) step();
    step();
    chk_out("pre_rst_lit", 4'b0001, SEG_TAB[4], 1'b0);
    step();
    step();
    chk_out("pre_rst_lit3", 4'b0001, SEG_TAB[4], 1'b0);
    chk_idx("pre_rst_lit3", 0);
    step();
    chk_out("pre_rst_lit4", 4'b0001, SEG_TAB[4], 1'b0);
    chk_idx("pre_rst_lit4", 1);
    step();
    step();
    step();
    chk_out("pre_rst_d1", 4'b0010, SEG_TAB[3], 1'b0);
    reset = 1'b1;
    #2;
    chk_out("rst_async", 4'b0000, 7'h00, 1'b0);
    chk_idx("rst_async", 0);
    step();
    chk_out("rst_hold", 4'b0000, 7'h00, 1'b0);
    reset = 1'b0;
    frame(4'b0000, 4'b0000);

    // Sweep digit 0 through every glyph, changing it each lit cycle.
    for (int f = 0; f < 4; f++) begin
      repeat (2) begin
        step();
        chk_out("sweep_guard", 4'b0000, 7'h00, 1'b0);
      end
      for (int c = 0; c < 4; c++) begin
        digits[3:0] = 4'(4 * f + c);
        step();
        chk_out($sformatf("sweep_%0h", 4 * f + c), 4'b0001, SEG_TAB[4 * f + c], 1'b0);
      end
      slot(1, SEG_TAB[3], 1'b0, 1'b0);
      slot(2, SEG_TAB[2], 1'b0, 1'b0);
      slot(3, SEG_TAB[1], 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
